// File: rtl/freq_sync_tx.sv
// Master-side counter synchroniser: free-running clk/8 reference, slave inhibit
// sequencing, and a local tick counter aligned to the slave counters.
module freq_sync_tx #(
   parameter int unsigned INH_PERIODS = 4,
   parameter int unsigned LAT         = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   output logic        freqout,
   output logic        inhibit,
   output logic [21:0] counter,
   output logic        busy,
   output logic        running
);

   typedef enum logic [1:0] {IDLE, HOLD, DELAY, RUN} state_e;

   state_e      state_q;
   logic [2:0]  div_q;
   logic [3:0]  per_q;
   logic [2:0]  lat_q;
   logic        inhibit_q;
   logic        busy_q;
   logic        running_q;
   logic [21:0] counter_q;
   logic        fre;

   // The edge that takes div from 3 to 4 is the freqout rising edge.
   assign fre = (div_q == 3'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= 3'd0;
         per_q     <= 4'd0;
         lat_q     <= 3'd0;
         inhibit_q <= 1'b1;
         busy_q    <= 1'b0;
         running_q <= 1'b0;
         counter_q <= 22'd0;
      end else begin
         // The divider is never touched by start/stop, so freqout keeps its phase.
         div_q <= div_q + 3'd1;
         if (stop) begin
            state_q   <= IDLE;
            per_q     <= 4'd0;
            inhibit_q <= 1'b1;
            busy_q    <= 1'b0;
            running_q <= 1'b0;
            counter_q <= 22'd0;
         end else if (start) begin
            state_q   <= HOLD;
            per_q     <= 4'd0;
            inhibit_q <= 1'b1;
            busy_q    <= 1'b1;
            running_q <= 1'b0;
            counter_q <= 22'd0;
         end else begin
            unique case (state_q)
               IDLE: ;
               HOLD: begin
                  if (fre) begin
                     if (per_q == 4'(INH_PERIODS - 1)) begin
                        inhibit_q <= 1'b0;
                        lat_q     <= 3'd0;
                        if (LAT > 0) begin
                           state_q <= DELAY;
                        end else begin
                           state_q   <= RUN;
                           busy_q    <= 1'b0;
                           running_q <= 1'b1;
                        end
                     end else begin
                        per_q <= per_q + 4'd1;
                     end
                  end
               end
               DELAY: begin
                  // LAT edges are spent here; the first count lands one edge after RUN entry.
                  if (lat_q == 3'(LAT - 1)) begin
                     state_q   <= RUN;
                     busy_q    <= 1'b0;
                     running_q <= 1'b1;
                  end else begin
                     lat_q <= lat_q + 3'd1;
                  end
               end
               RUN: counter_q <= counter_q + 22'd1;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign freqout = div_q[2];
   assign inhibit = inhibit_q;
   assign counter = counter_q;
   assign busy    = busy_q;
   assign running = running_q;

endmodule

// File: doc/freq_sync_tx.md
FREQ_SYNC_TX -- requirements
Module: freq_sync_tx

Interface
REQ-001 Parameter INH_PERIODS, default 4: number of freqout rising edges for which inhibit is held after a start; legal range 1..15.
REQ-002 Parameter LAT, default 2: extra clk cycles the local counter waits after inhibit release, matching slave-side latching delay; legal range 0..7.
REQ-003 clk  input  1  125 MHz system clock; the only clock in the block.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  synchronous one-cycle request to (re)start the synchronized count.
REQ-006 stop  input  1  synchronous one-cycle request to halt counting and re-assert inhibit.
REQ-007 freqout  output  1  reference frequency to slaves, clk/8 (15.625 MHz), 50% duty, flop output.
REQ-008 inhibit  output  1  counter-inhibit to slaves, flop output.
REQ-009 counter  output  22  local 125 MHz tick count, aligned to slave counters.
REQ-010 busy  output  1  high while in HOLD or DELAY.
REQ-011 running  output  1  high while in RUN.

Function
REQ-012 A 3-bit divider div SHALL increment by 1 every clk edge and wrap 7->0, free-running in all states.
REQ-013 freqout SHALL equal div[2] at all times: low for div 0..3, high for div 4..7; a freqout rising edge ("FRE") is the clk edge on which div goes 3->4.
REQ-014 States SHALL be IDLE, HOLD, DELAY, RUN.
REQ-015 IDLE: inhibit=1, counter=0; start -> HOLD.
REQ-016 HOLD: inhibit=1, counter=0; a 4-bit period count, cleared on entry, increments on each FRE; the entry edge itself SHALL NOT count.
REQ-017 HOLD exit: on the FRE where the period count reaches INH_PERIODS, inhibit SHALL fall on that same edge; next state DELAY if LAT>0, else RUN.
REQ-018 DELAY: inhibit=0, counter=0; after LAT clk edges -> RUN.
REQ-019 RUN: inhibit=0; counter SHALL increment by 1 every clk edge; the first increment (0->1) occurs LAT+1 clk edges after the inhibit-fall edge.
REQ-020 Counter SHALL wrap 4194303 -> 0 without any state change or flag.
REQ-021 stop in HOLD, DELAY or RUN SHALL, on the next edge, set inhibit=1, counter=0, state IDLE; stop in IDLE has no effect.
REQ-022 start in RUN, DELAY or HOLD SHALL restart: inhibit=1, counter=0, state HOLD with period count cleared.
REQ-023 start and stop in the same cycle: stop SHALL win.
REQ-024 The divider SHALL NOT be reset or re-phased by start/stop; freqout never glitches or changes period.

Reset
REQ-025 While reset is high: div=0, freqout=0, inhibit=1, counter=0, busy=0, running=0, state IDLE, period count=0.
REQ-026 Reset assertion SHALL take effect immediately, without a clk edge, including mid-HOLD or mid-RUN.
REQ-027 After reset release, div SHALL be 1 after the first clk edge; the first FRE is the 4th edge.

Verification
REQ-028 Reset release, no start, 64 clk -> freqout period 8 clk, 4 high/4 low, first rise on edge 4; inhibit=1; counter=0.
REQ-029 Defaults, start pulsed while div=0 -> busy next edge; inhibit falls on the 4th FRE after entry (freqout rising at the same edge); counter=1 three edges later (LAT=2), then +1 per clk; running=1.
REQ-030 Force counter run to 4194300, run 6 clk -> 4194301, 4194302, 4194303, 0, 1, 2; running stays 1, inhibit stays 0.
REQ-031 In RUN at counter=1000, pulse stop -> next edge inhibit=1, counter=0, running=0; freqout phase unchanged.
REQ-032 start and stop asserted together in RUN -> IDLE, inhibit=1; start alone in RUN at counter=500 -> HOLD, counter=0, inhibit released again after 4 further FREs.
REQ-033 Assert reset asynchronously mid-DELAY -> outputs go to REQ-025 values before the next clk edge; LAT=0 build: counter=1 on the edge after inhibit falls.
